sid_host_reg_rx: RTL and testbench

// - Receiving end of the host register-write port on tt_um_sid (ui_in/uio_in bus).
// - Synchronises the host write strobe, decodes voice/address, updates the per-voice

---
 rtl/sid_pkg.sv | 35 +++
 rtl/sid_sync_edge.sv | 39 +++
 rtl/sid_host_reg_rx.sv | 125 ++++++++++++
 tb/tb_sid_host_reg_rx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared constants for the SID host register-write receiver.
// Register map offsets, waveform-control bit masks, and field widths.
// The packed write-command layout is also defined here.
package sid_pkg;

  // Per-voice register offsets (ui_in[2:0])
  localparam logic [2:0] REG_FREQ_LO = 3'd0;
  localparam logic [2:0] REG_FREQ_HI = 3'd1;
  localparam logic [2:0] REG_PW_LO   = 3'd2;
  localparam logic [2:0] REG_PW_HI   = 3'd3;
  localparam logic [2:0] REG_ATK_DEC = 3'd4;
  localparam logic [2:0] REG_SUS_REL = 3'd5;
  localparam logic [2:0] REG_WAVE    = 3'd6;
  localparam logic [2:0] REG_RSVD    = 3'd7;

  // Waveform/control byte bit masks
  localparam logic [7:0] WAV_GATE  = 8'h01;
  localparam logic [7:0] WAV_TRI   = 8'h10;
  localparam logic [7:0] WAV_SAW   = 8'h20;
  localparam logic [7:0] WAV_PULSE = 8'h40;
  localparam logic [7:0] WAV_NOISE = 8'h80;

  localparam int FREQ_W = 16;
  localparam int PW_W   = 12;
  localparam int BYTE_W = 8;
  localparam int BUS_W  = 13;

  // Write command as carried through the synchroniser: {voice, addr, data}
  typedef struct packed {
    logic [1:0] voice;
    logic [2:0] addr;
    logic [7:0] data;
  } wr_bus_t;

endpackage

// File: rtl/sid_sync_edge.sv
// Synchroniser for the host write strobe plus its bus, with a rising-edge pulse.
// Latency: strobe sampled at edge k -> rise/bus_out valid after edge k+SYNC_STAGES-1.
// No backpressure; the host must keep the strobe low >= 1 clk between writes.
// Ports: clk, rst_n, stb (async strobe), bus (async data), bus_out (aligned bus), rise (1-clk pulse).
module sid_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stb,
  input  logic [W-1:0] bus,
  output logic [W-1:0] bus_out,
  output logic         rise
);

  logic [SYNC_STAGES-1:0] stb_q;
  logic [W-1:0]           bus_q [SYNC_STAGES];

  // The bus travels in lockstep with the strobe, so whatever was on the bus
  // when the strobe was first sampled high is what bus_out shows with rise.
  // rise is registered from the second-to-last stage so it lines up with
  // the last bus stage without any combinational edge detect on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) bus_q[i] <= '0;
      rise  <= 1'b0;
    end else begin
      stb_q    <= {stb_q[SYNC_STAGES-2:0], stb};
      bus_q[0] <= bus;
      for (int i = 1; i < SYNC_STAGES; i++) bus_q[i] <= bus_q[i-1];
      rise     <= stb_q[SYNC_STAGES-2] & ~stb_q[SYNC_STAGES-1];
    end
  end

  assign bus_out = bus_q[SYNC_STAGES-1];

endmodule

// File: rtl/sid_host_reg_rx.sv
// Host register-write receiver: decodes synchronised writes into the per-voice register bank.
// Latency: strobe sampled at edge k -> wr_stb_o after edge k+1 -> registers updated after edge k+2.
// No backpressure; every strobe rising edge is a write. Voices >= NUM_VOICES are dropped and flagged.
// Ports: clk, rst_n, ui_in {stb, -, -, voice[1:0], addr[2:0]}, uio_in data; outputs are the
//        flattened register bank, gate edge pulses, write pulse and sticky bad-voice flag.
module sid_host_reg_rx
  import sid_pkg::*;
#(
  parameter int NUM_VOICES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   ui_in,
  input  logic [7:0]                   uio_in,
  output logic [FREQ_W*NUM_VOICES-1:0] freq_o,
  output logic [PW_W*NUM_VOICES-1:0]   pw_o,
  output logic [BYTE_W*NUM_VOICES-1:0] atk_dec_o,
  output logic [BYTE_W*NUM_VOICES-1:0] sus_rel_o,
  output logic [BYTE_W*NUM_VOICES-1:0] wav_o,
  output logic [NUM_VOICES-1:0]        gate_rise_o,
  output logic [NUM_VOICES-1:0]        gate_fall_o,
  output logic                         wr_stb_o,
  output logic                         bad_voice_o
);

  logic [BUS_W-1:0] sync_bus;
  logic             wr;
  wr_bus_t          cmd;
  logic             voice_ok;
  logic             new_gate;
  logic             unused_bits;

  logic [FREQ_W-1:0] freq_q    [NUM_VOICES];
  logic [PW_W-1:0]   pw_q      [NUM_VOICES];
  logic [7:0]        ad_q      [NUM_VOICES];
  logic [7:0]        sr_q      [NUM_VOICES];
  logic [7:0]        wav_q     [NUM_VOICES];
  logic [7:0]        freq_hi_q [NUM_VOICES];
  logic [3:0]        pw_hi_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_rise_q;
  logic [NUM_VOICES-1:0] gate_fall_q;
  logic                  bad_q;

  // ui_in[6:5] carry nothing.
  assign unused_bits = &{1'b0, ui_in[6:5]};

  sid_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .W          (BUS_W)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .stb    (ui_in[7]),
    .bus    ({ui_in[4:0], uio_in}),
    .bus_out(sync_bus),
    .rise   (wr)
  );

  assign cmd      = wr_bus_t'(sync_bus);
  assign voice_ok = ({30'd0, cmd.voice} < NUM_VOICES);
  assign new_gate = |(cmd.data & WAV_GATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_q[v]    <= '0;
        pw_q[v]      <= '0;
        ad_q[v]      <= '0;
        sr_q[v]      <= '0;
        wav_q[v]     <= '0;
        freq_hi_q[v] <= '0;
        pw_hi_q[v]   <= '0;
      end
      gate_rise_q <= '0;
      gate_fall_q <= '0;
      bad_q       <= 1'b0;
    end else begin
      // Gate pulses last exactly the one cycle following the WAVE commit.
      gate_rise_q <= '0;
      gate_fall_q <= '0;
      if (wr) begin
        if (!voice_ok) begin
          bad_q <= 1'b1;
        end else begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (cmd.voice == 2'(v)) begin
              case (cmd.addr)
                // HI bytes only stage; the LO write commits the whole word
                // in one edge so the voices never see a half-updated value.
                REG_FREQ_LO: freq_q[v]    <= {freq_hi_q[v], cmd.data};
                REG_FREQ_HI: freq_hi_q[v] <= cmd.data;
                REG_PW_LO:   pw_q[v]      <= {pw_hi_q[v], cmd.data};
                REG_PW_HI:   pw_hi_q[v]   <= cmd.data[3:0];
                REG_ATK_DEC: ad_q[v]      <= cmd.data;
                REG_SUS_REL: sr_q[v]      <= cmd.data;
                REG_WAVE: begin
                  wav_q[v]       <= cmd.data;
                  gate_rise_q[v] <= new_gate & ~|(wav_q[v] & WAV_GATE);
                  gate_fall_q[v] <= ~new_gate & |(wav_q[v] & WAV_GATE);
                end
                REG_RSVD: ;
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_flat
    assign freq_o[FREQ_W*gv +: FREQ_W]    = freq_q[gv];
    assign pw_o[PW_W*gv +: PW_W]          = pw_q[gv];
    assign atk_dec_o[BYTE_W*gv +: BYTE_W] = ad_q[gv];
    assign sus_rel_o[BYTE_W*gv +: BYTE_W] = sr_q[gv];
    assign wav_o[BYTE_W*gv +: BYTE_W]     = wav_q[gv];
  end

  assign gate_rise_o = gate_rise_q;
  assign gate_fall_o = gate_fall_q;
  assign wr_stb_o    = wr;
  assign bad_voice_o = bad_q;

endmodule

// File: tb/tb_sid_host_reg_rx.sv
`timescale 1ns/1ps
module tb_sid_host_reg_rx;

  localparam int NV = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uio_in;
  logic [47:0] freq_o;
  logic [35:0] pw_o;
  logic [23:0] atk_dec_o;
  logic [23:0] sus_rel_o;
  logic [23:0] wav_o;
  logic [2:0]  gate_rise_o;
  logic [2:0]  gate_fall_o;
  logic        wr_stb_o;
  logic        bad_voice_o;

  always #5 clk = ~clk;

  sid_host_reg_rx #(.NUM_VOICES(NV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uio_in(uio_in),
    .freq_o(freq_o), .pw_o(pw_o), .atk_dec_o(atk_dec_o), .sus_rel_o(sus_rel_o),
    .wav_o(wav_o), .gate_rise_o(gate_rise_o), .gate_fall_o(gate_fall_o),
    .wr_stb_o(wr_stb_o), .bad_voice_o(bad_voice_o)
  );

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pulses = 0;

  typedef struct {
    logic [47:0] freq;
    logic [35:0] pw;
    logic [23:0] ad, sr, wav;
    logic [2:0]  rise, fall;
    logic        bad;
  } snap_t;
  snap_t sb_q[$];

  // Reference model of the register bank
  logic [15:0] m_freq [NV];
  logic [11:0] m_pw   [NV];
  logic [7:0]  m_ad   [NV];
  logic [7:0]  m_sr   [NV];
  logic [7:0]  m_wav  [NV];
  logic [7:0]  m_fhi  [NV];
  logic [3:0]  m_phi  [NV];
  logic        m_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_freq[i] = '0; m_pw[i] = '0; m_ad[i] = '0; m_sr[i] = '0;
      m_wav[i] = '0; m_fhi[i] = '0; m_phi[i] = '0;
    end
    m_bad = 1'b0;
  endtask

  task automatic model_push(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d);
    snap_t s;
    s.rise = '0;
    s.fall = '0;
    if (int'(v) >= NV) m_bad = 1'b1;
    else begin
      case (a)
        3'd0: m_freq[v] = {m_fhi[v], d};
        3'd1: m_fhi[v]  = d;
        3'd2: m_pw[v]   = {m_phi[v], d};
        3'd3: m_phi[v]  = d[3:0];
        3'd4: m_ad[v]   = d;
        3'd5: m_sr[v]   = d;
        3'd6: begin
          s.rise[v] = d[0] & ~m_wav[v][0];
          s.fall[v] = ~d[0] & m_wav[v][0];
          m_wav[v]  = d;
        end
        default: ;
      endcase
    end
    for (int i = 0; i < NV; i++) begin
      s.freq[16*i +: 16] = m_freq[i];
      s.pw[12*i +: 12]   = m_pw[i];
      s.ad[8*i +: 8]     = m_ad[i];
      s.sr[8*i +: 8]     = m_sr[i];
      s.wav[8*i +: 8]    = m_wav[i];
    end
    s.bad = m_bad;
    sb_q.push_back(s);
    pushes++;
  endtask

  // Scoreboard monitor: a wr_stb_o pulse means the commit lands on the next
  // edge, so the expected snapshot is compared one negedge later.
  logic pending = 1'b0;
  always @(negedge clk) begin
    snap_t e;
    if (!rst_n) begin
      sb_q.delete();
      pending = 1'b0;
    end else begin
      if (pending) begin
        e = sb_q.pop_front();
        chk("sb_freq", freq_o, e.freq);
        chk("sb_pw", pw_o, e.pw);
        chk("sb_atk_dec", atk_dec_o, e.ad);
        chk("sb_sus_rel", sus_rel_o, e.sr);
        chk("sb_wav", wav_o, e.wav);
        chk("sb_gate_rise", gate_rise_o, e.rise);
        chk("sb_gate_fall", gate_fall_o, e.fall);
        chk("sb_bad_voice", bad_voice_o, e.bad);
        pending = 1'b0;
      end else begin
        chk("gate_idle", {gate_rise_o, gate_fall_o}, 6'b0);
      end
      if (wr_stb_o) begin
        pulses++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_write: wr_stb_o=1 with no write outstanding");
        end else pending = 1'b1;
      end
    end
  end

  task automatic do_write(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ui_in  = {1'b0, 2'b00, v, a};
    uio_in = d;
    @(negedge clk);
    ui_in[7] = 1'b1;
    model_push(v, a, d);
    @(negedge clk);
    ui_in[7] = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_freq"}, freq_o, 0);
    chk({name, "_pw"}, pw_o, 0);
    chk({name, "_ad_sr"}, {atk_dec_o, sus_rel_o}, 0);
    chk({name, "_wav_misc"}, {wav_o, gate_rise_o, gate_fall_o, wr_stb_o, bad_voice_o}, 0);
  endtask

  // sel: 0 freq, 1 pw, 2 atk_dec, 3 sus_rel, 4 wav, 5 bad_voice
  function automatic logic [15:0] get_out(input int sel, input int v);
    case (sel)
      0: return freq_o[16*v +: 16];
      1: return {4'b0, pw_o[12*v +: 12]};
      2: return {8'b0, atk_dec_o[8*v +: 8]};
      3: return {8'b0, sus_rel_o[8*v +: 8]};
      4: return {8'b0, wav_o[8*v +: 8]};
      default: return {15'b0, bad_voice_o};
    endcase
  endfunction

  typedef struct {
    logic [1:0]  v;
    logic [2:0]  a;
    logic [7:0]  d;
    int          sel;
    int          sv;
    logic [15:0] exp;
    logic [2:0]  rise;
    logic [2:0]  fall;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //            v     a     d      sel sv  exp        rise    fall
    tbl[0]  = '{2'd1, 3'd1, 8'h12, 0, 1, 16'h0000, 3'b000, 3'b000};
    tbl[1]  = '{2'd1, 3'd0, 8'h34, 0, 1, 16'h1234, 3'b000, 3'b000};
    tbl[2]  = '{2'd1, 3'd0, 8'h56, 0, 1, 16'h1256, 3'b000, 3'b000};
    tbl[3]  = '{2'd1, 3'd3, 8'hF8, 1, 1, 16'h0000, 3'b000, 3'b000};
    tbl[4]  = '{2'd1, 3'd2, 8'h80, 1, 1, 16'h0880, 3'b000, 3'b000};
    tbl[5]  = '{2'd0, 3'd4, 8'hA5, 2, 0, 16'h00A5, 3'b000, 3'b000};
    tbl[6]  = '{2'd0, 3'd5, 8'h3C, 3, 0, 16'h003C, 3'b000, 3'b000};
    tbl[7]  = '{2'd2, 3'd6, 8'h11, 4, 2, 16'h0011, 3'b100, 3'b000};
    tbl[8]  = '{2'd2, 3'd6, 8'h11, 4, 2, 16'h0011, 3'b000, 3'b000};
    tbl[9]  = '{2'd2, 3'd6, 8'h10, 4, 2, 16'h0010, 3'b000, 3'b100};
    tbl[10] = '{2'd0, 3'd7, 8'hFF, 0, 0, 16'h0011, 3'b000, 3'b000};
    tbl[11] = '{2'd2, 3'd0, 8'hFF, 0, 2, 16'h00FF, 3'b000, 3'b000};
    tbl[12] = '{2'd3, 3'd6, 8'h21, 5, 0, 16'h0001, 3'b000, 3'b000};

    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // V0 FREQ_LO = 17, edge-exact latency
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'd17;
    @(negedge clk);
    ui_in[7] = 1'b1;
    model_push(2'd0, 3'd0, 8'd17);
    @(posedge clk); #1;
    chk("lat_k_stb", wr_stb_o, 0);
    @(negedge clk);
    ui_in[7] = 1'b0;
    @(posedge clk); #1;
    chk("lat_k1_stb", wr_stb_o, 1);
    chk("lat_k1_freq", freq_o[15:0], 16'h0000);
    @(posedge clk); #1;
    chk("lat_k2_stb", wr_stb_o, 0);
    chk("lat_k2_freq", freq_o[15:0], 16'h0011);

    // Table-driven single writes
    for (int i = 0; i < 13; i++) begin
      do_write(tbl[i].v, tbl[i].a, tbl[i].d);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_reg", i), get_out(tbl[i].sel, tbl[i].sv), tbl[i].exp);
      chk($sformatf("tbl%0d_rise", i), gate_rise_o, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), gate_fall_o, tbl[i].fall);
    end
    chk("v2_wav_after_bad", wav_o[23:16], 8'h10);

    // Back-to-back writes on the 3-clock cadence
    do_write(2'd0, 3'd1, 8'hAB);
    do_write(2'd0, 3'd0, 8'hCD);
    do_write(2'd1, 3'd6, 8'h41);
    do_write(2'd1, 3'd6, 8'h40);
    repeat (3) @(negedge clk);
    chk("b2b_freq0", freq_o[15:0], 16'hABCD);
    chk("b2b_wav1", wav_o[15:8], 8'h40);

    // Strobe held high for 20 clocks: exactly one write
    @(negedge clk);
    ui_in  = {1'b0, 2'b00, 2'd0, 3'd4};
    uio_in = 8'hC3;
    @(negedge clk);
    ui_in[7] = 1'b1;
    model_push(2'd0, 3'd4, 8'hC3);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_stb_o) cnt++;
    end
    ui_in[7] = 1'b0;
    chk("held_strobe_writes", cnt, 1);
    repeat (3) @(negedge clk);
    chk("held_strobe_ad0", atk_dec_o[7:0], 8'hC3);
    chk("bad_voice_sticky", bad_voice_o, 1);

    // Reset during a write in flight: write discarded, everything clears
    @(negedge clk);
    ui_in  = {1'b0, 2'b00, 2'd0, 3'd6};
    uio_in = 8'h01;
    @(negedge clk);
    ui_in[7] = 1'b1;
    @(negedge clk);
    rst_n    = 1'b0;
    ui_in[7] = 1'b0;
    model_reset();
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_all_zero("post_rst");

    // Strobe already high across reset release is seen as a rising edge
    @(negedge clk);
    rst_n  = 1'b0;
    ui_in  = {1'b1, 2'b00, 2'd1, 3'd6};
    uio_in = 8'h01;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_push(2'd1, 3'd6, 8'h01);
    repeat (4) @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_held_wav1", wav_o[15:8], 8'h01);
    chk("rst_held_bad", bad_voice_o, 0);

    chk("pulse_count", pulses, pushes);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
